// File: rtl/hazard_detect_pkg.sv
// ----------------------------------------------------------------------------
// hazard_detect_pkg : shared codes, stage record type and helpers  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package hazard_detect_pkg;

  localparam logic [2:0] WB_NONE = 3'b000;
  localparam logic [2:0] WB_ALU  = 3'b001;
  localparam logic [2:0] WB_RS   = 3'b010;
  localparam logic [2:0] WB_RAM  = 3'b011;
  localparam logic [2:0] WB_HI   = 3'b100;
  localparam logic [2:0] WB_LO   = 3'b101;
  localparam logic [2:0] WB_PC8  = 3'b110;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int CNT_W_DEF      = 6;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wreg;
    logic       load;
  } stage_rec_t;

  function automatic stage_rec_t make_rec(
    input logic       v,
    input logic       we,
    input logic [4:0] wreg,
    input logic [2:0] wsel
  );
    stage_rec_t r;
    r.v    = v;
    r.we   = we;
    r.wreg = wreg;
    r.load = (wsel == WB_RAM);
    return r;
  endfunction

  // $0 is never a real producer, so it can never raise a hazard.
  function automatic logic rec_match(
    input stage_rec_t rec,
    input logic       used,
    input logic [4:0] idx
  );
    return used && (idx != 5'd0) && rec.v && rec.we &&
           (rec.wreg != 5'd0) && (rec.wreg == idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect_hilo_busy_timer.sv
// ----------------------------------------------------------------------------
// hilo_busy_timer : divider occupancy counter driving the HI/LO busy flag (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module hilo_busy_timer
  import hazard_detect_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Decrement is deliberately not gated by the pipeline hold: the divider keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= C_LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect : ID-stage bypass hazard flags, load-use and HI/LO stalls (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       hold,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] id_wreg,
  input  logic       id_rf_we,
  input  logic [2:0] id_rf_wsel,
  input  logic       id_hilo_use,
  input  logic       id_is_div,
  output logic       id_ex_hazard_mem,
  output logic       id_ex_rs_hazard_reg,
  output logic       id_ex_rt_hazard_reg,
  output logic       id_mem_rs_hazard_mem,
  output logic       id_mem_rt_hazard_mem,
  output logic       id_mem_rs_hazard_reg,
  output logic       id_mem_rt_hazard_reg,
  output logic       stall,
  output logic       hilo_busy
);

  stage_rec_t r_ex;
  stage_rec_t r_mem;
  stage_rec_t w_id_rec;

  logic w_rs_ex;
  logic w_rt_ex;
  logic w_rs_mem;
  logic w_rt_mem;
  logic w_div_issue;

  // A stalled ID instruction must not enter EX; it becomes a bubble instead.
  always_comb begin
    w_id_rec = make_rec(id_valid & ~stall, id_rf_we, id_wreg, id_rf_wsel);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (!hold) begin
      r_mem <= r_ex;
      r_ex  <= w_id_rec;
    end
  end

  // The younger producer in EX shadows any older one in MEM for the same operand.
  always_comb begin
    w_rs_ex  = rec_match(r_ex, id_rs_used, id_rs);
    w_rt_ex  = rec_match(r_ex, id_rt_used, id_rt);
    w_rs_mem = rec_match(r_mem, id_rs_used, id_rs) & ~w_rs_ex;
    w_rt_mem = rec_match(r_mem, id_rt_used, id_rt) & ~w_rt_ex;
  end

  always_comb begin
    id_ex_hazard_mem     = (w_rs_ex | w_rt_ex) & r_ex.load;
    id_ex_rs_hazard_reg  = w_rs_ex & ~r_ex.load;
    id_ex_rt_hazard_reg  = w_rt_ex & ~r_ex.load;
    id_mem_rs_hazard_mem = w_rs_mem & r_mem.load;
    id_mem_rt_hazard_mem = w_rt_mem & r_mem.load;
    id_mem_rs_hazard_reg = w_rs_mem & ~r_mem.load;
    id_mem_rt_hazard_reg = w_rt_mem & ~r_mem.load;
  end

  assign stall       = id_valid & (id_ex_hazard_mem | (hilo_busy & id_hilo_use));
  assign w_div_issue = id_valid & id_is_div & ~stall & ~hold;

  hilo_busy_timer #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hilo_busy_timer (
    .clk    (clk),
    .rst_n  (resetn),
    .i_load (w_div_issue),
    .o_busy (hilo_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_detect.sv
// ----------------------------------------------------------------------------
// tb_hazard_detect : directed and randomized checks of hazard_detect (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_detect;
  import hazard_detect_pkg::*;

  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic hold = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic id_rs_used = 1'b0;
  logic id_rt_used = 1'b0;
  logic [4:0] id_wreg = '0;
  logic id_rf_we = 1'b0;
  logic [2:0] id_rf_wsel = '0;
  logic id_hilo_use = 1'b0;
  logic id_is_div = 1'b0;

  logic id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
  logic id_mem_rs_hazard_mem, id_mem_rt_hazard_mem;
  logic id_mem_rs_hazard_reg, id_mem_rt_hazard_reg;
  logic stall, hilo_busy;

  hazard_detect #(.DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .hold                 (hold),
    .id_valid             (id_valid),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_rs_used           (id_rs_used),
    .id_rt_used           (id_rt_used),
    .id_wreg              (id_wreg),
    .id_rf_we             (id_rf_we),
    .id_rf_wsel           (id_rf_wsel),
    .id_hilo_use          (id_hilo_use),
    .id_is_div            (id_is_div),
    .id_ex_hazard_mem     (id_ex_hazard_mem),
    .id_ex_rs_hazard_reg  (id_ex_rs_hazard_reg),
    .id_ex_rt_hazard_reg  (id_ex_rt_hazard_reg),
    .id_mem_rs_hazard_mem (id_mem_rs_hazard_mem),
    .id_mem_rt_hazard_mem (id_mem_rt_hazard_mem),
    .id_mem_rs_hazard_reg (id_mem_rs_hazard_reg),
    .id_mem_rt_hazard_reg (id_mem_rt_hazard_reg),
    .stall                (stall),
    .hilo_busy            (hilo_busy)
  );

  always #5 clk = ~clk;

  // Bit order: ex_mem, ex_rs_reg, ex_rt_reg, mem_rs_mem, mem_rt_mem, mem_rs_reg, mem_rt_reg, stall, busy
  logic [8:0] act_v;
  assign act_v = {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg,
                  id_mem_rs_hazard_mem, id_mem_rt_hazard_mem,
                  id_mem_rs_hazard_reg, id_mem_rt_hazard_reg, stall, hilo_busy};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  // Reference: instructions in flight, index 0 = EX, 1 = MEM; divider modelled as a release cycle.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [2:0] wsel;
    logic [4:0] wreg;
  } minstr_t;

  minstr_t m_stage [2] = '{'0, '0};
  int cyc     = 0;
  int free_at = 0;

  function automatic logic [8:0] model_out();
    logic [8:0] r;
    logic [4:0] idx;
    logic       used;
    int         prod;
    r = '0;
    for (int op = 0; op < 2; op++) begin
      idx  = (op == 0) ? id_rs : id_rt;
      used = (op == 0) ? id_rs_used : id_rt_used;
      prod = -1;
      if (used && idx != 5'd0) begin
        // scan oldest to youngest so the youngest writer is the one kept
        for (int s = 1; s >= 0; s--)
          if (m_stage[s].valid && m_stage[s].we && m_stage[s].wreg == idx) prod = s;
      end
      if (prod == 0) begin
        if (m_stage[0].wsel == WB_RAM) r[8] = 1'b1;
        else r[(op == 0) ? 7 : 6] = 1'b1;
      end else if (prod == 1) begin
        if (m_stage[1].wsel == WB_RAM) r[(op == 0) ? 5 : 4] = 1'b1;
        else r[(op == 0) ? 3 : 2] = 1'b1;
      end
    end
    r[0] = (cyc < free_at);
    r[1] = id_valid && (r[8] || (r[0] && id_hilo_use));
    return r;
  endfunction

  function automatic logic model_stall();
    logic [8:0] r;
    r = model_out();
    return r[1];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_stage[0] <= '0;
      m_stage[1] <= '0;
      free_at    <= 0;
    end else if (!hold) begin
      m_stage[1] <= m_stage[0];
      m_stage[0] <= (id_valid && !model_stall()) ?
                    {1'b1, id_rf_we, id_rf_wsel, id_wreg} : '0;
      if (id_valid && id_is_div && !model_stall()) free_at <= cyc + 1 + DIVC;
    end
  end

  always @(negedge clk) chk("model", act_v, model_out());

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] wr,
                        input logic we, input logic [2:0] ws, input logic hl, input logic dv);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rs_used  = rsu;
    id_rt_used  = rtu;
    id_wreg     = wr;
    id_rf_we    = we;
    id_rf_wsel  = ws;
    id_hilo_use = hl;
    id_is_div   = dv;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    hold   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, WB_NONE, 0, 0);
    nxt();
    @(negedge clk);
    chk("reset", act_v, 9'b000000000);
    nxt();
    resetn = 1'b1;
  endtask

  initial begin
    do_reset();

    // lw $2 then add $3,$2,$4: one stall cycle, then MEM load flag
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, WB_RAM, 0, 0);
    nxt();
    set_id(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, WB_ALU, 0, 0);
    @(negedge clk); chk("lu_stall", act_v, 9'b100000010);
    nxt();
    @(negedge clk); chk("lu_mem", act_v, 9'b000100000);

    // lw $2 in EX, ID not valid: flag computed, no stall
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, WB_RAM, 0, 0);
    nxt();
    set_id(0, 5'd2, 5'd0, 1, 0, 5'd3, 1, WB_ALU, 0, 0);
    @(negedge clk); chk("novalid", act_v, 9'b100000000);

    // addu $5 in EX and MEM, ID reads rt=$5
    do_reset();
    set_id(1, 5'd1, 5'd1, 1, 1, 5'd5, 1, WB_ALU, 0, 0);
    nxt();
    set_id(1, 5'd1, 5'd1, 1, 1, 5'd5, 1, WB_ALU, 0, 0);
    nxt();
    set_id(1, 5'd6, 5'd5, 1, 1, 5'd9, 1, WB_ALU, 0, 0);
    @(negedge clk); chk("ex_masks_mem", act_v, 9'b001000000);

    // addu $0 in EX, ID reads $0
    do_reset();
    set_id(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, WB_ALU, 0, 0);
    nxt();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, WB_ALU, 0, 0);
    @(negedge clk); chk("zero_reg", act_v, 9'b000000000);

    // ori $7 in MEM, beq $7,$7
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, WB_ALU, 0, 0);
    nxt();
    set_id(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, WB_NONE, 0, 0);
    nxt();
    set_id(1, 5'd7, 5'd7, 1, 1, 5'd0, 0, WB_NONE, 0, 0);
    @(negedge clk); chk("mem_both", act_v, 9'b000001100);

    // div at cycle 0, mflo at cycle 1: stall through cycle 32
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, WB_NONE, 1, 1);
    @(negedge clk); chk("div_issue", act_v, 9'b000000000);
    for (int k = 1; k <= DIVC; k++) begin
      nxt();
      set_id(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, WB_LO, 1, 0);
      @(negedge clk); chk("div_busy", act_v, 9'b000000011);
    end
    nxt();
    @(negedge clk); chk("div_done", act_v, 9'b000000000);

    // load-use with hold, then async reset mid-stall
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, WB_RAM, 0, 0);
    nxt();
    set_id(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, WB_ALU, 0, 0);
    hold = 1'b1;
    @(negedge clk); chk("hold_start", act_v, 9'b100000010);
    for (int k = 0; k < 3; k++) begin
      nxt();
      @(negedge clk); chk("hold_frozen", act_v, 9'b100000010);
    end
    nxt();
    resetn = 1'b0;
    #1;
    chk("async_reset", act_v, 9'b000000000);
    hold = 1'b0;
    nxt();
    resetn = 1'b1;

    // randomized traffic on a small register set to provoke frequent hits
    for (int i = 0; i < 3000; i++) begin
      nxt();
      begin
        logic dv, hl;
        dv = ($urandom_range(0, 40) == 0);
        hl = dv || ($urandom_range(0, 3) == 0);
        set_id($urandom_range(0, 7) != 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
               3'($urandom_range(1, 6)), hl, dv);
      end
      hold   = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 499) != 0);
    end
    nxt();
    resetn = 1'b1;
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
